lfsr_capture_sequencer: RTL and testbench



---
 rtl/lfsr_capture_pkg.sv | 31 +++
 rtl/lfsr_capture_spin_cnt.sv | 28 ++
 rtl/lfsr_capture_sequencer.sv | 155 +++++++++++++++
 tb/tb_lfsr_capture_sequencer.sv | 325 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/lfsr_capture_pkg.sv
// Shared types and helpers for the LFSR capture sequencer.
// Holds the FSM state encoding plus popcount and thermometer-code checks on 7-bit values.
package lfsr_capture_pkg;

    typedef enum logic [2:0] {
        IDLE,
        SPIN,
        SETTLE,
        WRITE,
        DONE
    } state_t;

    function automatic logic [2:0] popcount7(input logic [6:0] i_v);
        logic [2:0] w_cnt;
        w_cnt = '0;
        for (int i = 0; i < 7; i++) begin
            w_cnt = w_cnt + {2'b00, i_v[i]};
        end
        return w_cnt;
    endfunction

    // A nonzero thermometer code is 2**k-1, so v+1 shares no set bit with v.
    function automatic logic is_thermo(input logic [6:0] i_v);
        logic [7:0] w_ext;
        logic [7:0] w_inc;
        w_ext = {1'b0, i_v};
        w_inc = w_ext + 8'd1;
        return (i_v != 7'd0) && ((w_inc & w_ext) == 8'd0);
    endfunction

endpackage

// File: rtl/lfsr_capture_spin_cnt.sv
// Loadable down-counter that times how long the generator runs per word.
// o_expire flags the last cycle of the run (count of one).
module lfsr_capture_spin_cnt #(
    parameter int SPIN_W = 8
) (
    input  logic              i_clk,
    input  logic              i_reset,
    input  logic              i_load,
    input  logic [SPIN_W-1:0] i_load_val,
    input  logic              i_dec,
    output logic              o_expire
);

    logic [SPIN_W-1:0] r_count;

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_count <= '0;
        end else if (i_load) begin
            r_count <= i_load_val;
        end else if (i_dec && (r_count != '0)) begin
            r_count <= r_count - SPIN_W'(1);
        end
    end

    assign o_expire = (r_count == SPIN_W'(1));

endmodule

// File: rtl/lfsr_capture_sequencer.sv
// Runs the thermometer random generator, freezes it, and writes NUM_WORDS captured values to memory.
// Define LFSR_CAPTURE_CHECK_EN to reject non-thermometer captures and raise a sticky o_chk_err.
//
// state  | meaning
// IDLE   | generator frozen, waiting for i_start
// SPIN   | generator running until the spin counter expires or i_capture_req
// SETTLE | generator frozen for one cycle, value latched at the end
// WRITE  | write request held until the memory accepts it
// DONE   | one-cycle completion pulse
module lfsr_capture_sequencer #(
    parameter int DATA_W    = 7,
    parameter int ADDR_W    = 4,
    parameter int NUM_WORDS = 16,
    parameter int SPIN_W    = 8,
    parameter int SUM_W     = ADDR_W + 3
) (
    input  logic              i_clk,
    input  logic              i_reset,
    input  logic              i_start,
    input  logic [SPIN_W-1:0] i_spin_len,
    input  logic              i_capture_req,
    input  logic [DATA_W-1:0] i_rnd_value,
    output logic              o_rnd_stop,
    output logic              o_mem_wr_valid,
    input  logic              i_mem_wr_ready,
    output logic [ADDR_W-1:0] o_mem_wr_addr,
    output logic [DATA_W-1:0] o_mem_wr_data,
    output logic              o_busy,
    output logic              o_done,
    output logic [SUM_W-1:0]  o_level_sum,
    output logic              o_chk_err
);

    import lfsr_capture_pkg::*;

    state_t            r_state;
    logic              r_rnd_stop;
    logic              r_valid;
    logic              r_busy;
    logic              r_done;
    logic              r_chk_err;
    logic [ADDR_W-1:0] r_addr;
    logic [DATA_W-1:0] r_data;
    logic [SUM_W-1:0]  r_level_sum;

    logic [SPIN_W-1:0] w_spin_load_val;
    logic              w_hs;
    logic              w_last;
    logic              w_data_ok;
    logic              w_load;
    logic              w_dec;
    logic              w_expire;

    assign w_spin_load_val = (i_spin_len == '0) ? SPIN_W'(1) : i_spin_len;
    assign w_hs            = (r_state == WRITE) && i_mem_wr_ready;
    assign w_last          = (r_addr == ADDR_W'(NUM_WORDS - 1));

`ifdef LFSR_CAPTURE_CHECK_EN
    assign w_data_ok = is_thermo(7'(i_rnd_value));
`else
    assign w_data_ok = 1'b1;
`endif

    // Every entry into SPIN reloads the counter from the live i_spin_len.
    assign w_load = ((r_state == IDLE) && i_start)
                  || (w_hs && !w_last)
                  || ((r_state == SETTLE) && !w_data_ok);
    assign w_dec  = (r_state == SPIN);

    lfsr_capture_spin_cnt #(
        .SPIN_W (SPIN_W)
    ) u_spin_cnt (
        .i_clk      (i_clk),
        .i_reset    (i_reset),
        .i_load     (w_load),
        .i_load_val (w_spin_load_val),
        .i_dec      (w_dec),
        .o_expire   (w_expire)
    );

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_state     <= IDLE;
            r_rnd_stop  <= 1'b1;
            r_valid     <= 1'b0;
            r_busy      <= 1'b0;
            r_done      <= 1'b0;
            r_chk_err   <= 1'b0;
            r_addr      <= '0;
            r_data      <= '0;
            r_level_sum <= '0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (i_start) begin
                        r_state     <= SPIN;
                        r_rnd_stop  <= 1'b0;
                        r_busy      <= 1'b1;
                        r_addr      <= '0;
                        r_level_sum <= '0;
                    end
                end
                SPIN: begin
                    if (w_expire || i_capture_req) begin
                        r_state    <= SETTLE;
                        r_rnd_stop <= 1'b1;
                    end
                end
                SETTLE: begin
                    if (w_data_ok) begin
                        r_data  <= i_rnd_value;
                        r_valid <= 1'b1;
                        r_state <= WRITE;
                    end else begin
                        r_chk_err  <= 1'b1;
                        r_rnd_stop <= 1'b0;
                        r_state    <= SPIN;
                    end
                end
                WRITE: begin
                    if (i_mem_wr_ready) begin
                        r_valid     <= 1'b0;
                        r_level_sum <= r_level_sum + SUM_W'(popcount7(7'(r_data)));
                        if (w_last) begin
                            r_done  <= 1'b1;
                            r_state <= DONE;
                        end else begin
                            r_addr     <= r_addr + ADDR_W'(1);
                            r_rnd_stop <= 1'b0;
                            r_state    <= SPIN;
                        end
                    end
                end
                DONE: begin
                    r_done  <= 1'b0;
                    r_busy  <= 1'b0;
                    r_state <= IDLE;
                end
                default: begin
                    r_state <= IDLE;
                end
            endcase
        end
    end

    assign o_rnd_stop     = r_rnd_stop;
    assign o_mem_wr_valid = r_valid;
    assign o_mem_wr_addr  = r_addr;
    assign o_mem_wr_data  = r_data;
    assign o_busy         = r_busy;
    assign o_done         = r_done;
    assign o_level_sum    = r_level_sum;
    assign o_chk_err      = r_chk_err;

endmodule

// File: tb/tb_lfsr_capture_sequencer.sv
// Scoreboard bench for lfsr_capture_sequencer with NUM_WORDS=4 and a thermometer generator model.
module tb_lfsr_capture_sequencer;

    localparam int DATA_W    = 7;
    localparam int ADDR_W    = 4;
    localparam int NUM_WORDS = 4;
    localparam int SPIN_W    = 8;
    localparam int SUM_W     = ADDR_W + 3;

    logic              clk = 1'b0;
    logic              reset = 1'b1;
    logic              start = 1'b0;
    logic              capture_req = 1'b0;
    logic              mem_wr_ready = 1'b0;
    logic [SPIN_W-1:0] spin_len = 8'd3;
    logic [DATA_W-1:0] rnd_value;
    logic              rnd_stop;
    logic              mem_wr_valid;
    logic [ADDR_W-1:0] mem_wr_addr;
    logic [DATA_W-1:0] mem_wr_data;
    logic              busy;
    logic              done;
    logic [SUM_W-1:0]  level_sum;
    logic              chk_err;

    typedef struct {
        logic [ADDR_W-1:0] addr;
        logic [DATA_W-1:0] data;
    } wr_t;

    wr_t sb[$];
    int  hs_cyc[$];
    int  checks = 0;
    int  failures = 0;
    int  cyc = 0;
    int  done_cnt = 0;
    int  s_cyc;

    // Generator model: steps through thermometer codes of level 1..7 while not stopped.
    logic              stub_en = 1'b0;
    logic [DATA_W-1:0] stub_val = '0;
    logic [2:0]        g_lvl = 3'd1;
    logic [7:0]        g_full;

    assign g_full    = (8'd1 << g_lvl) - 8'd1;
    assign rnd_value = stub_en ? stub_val : g_full[6:0];

    always @(posedge clk) begin
        if (reset) g_lvl <= 3'd1;
        else if (!rnd_stop) g_lvl <= (g_lvl == 3'd7) ? 3'd1 : g_lvl + 3'd1;
    end

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    lfsr_capture_sequencer #(
        .DATA_W    (DATA_W),
        .ADDR_W    (ADDR_W),
        .NUM_WORDS (NUM_WORDS),
        .SPIN_W    (SPIN_W),
        .SUM_W     (SUM_W)
    ) dut (
        .i_clk          (clk),
        .i_reset        (reset),
        .i_start        (start),
        .i_spin_len     (spin_len),
        .i_capture_req  (capture_req),
        .i_rnd_value    (rnd_value),
        .o_rnd_stop     (rnd_stop),
        .o_mem_wr_valid (mem_wr_valid),
        .i_mem_wr_ready (mem_wr_ready),
        .o_mem_wr_addr  (mem_wr_addr),
        .o_mem_wr_data  (mem_wr_data),
        .o_busy         (busy),
        .o_done         (done),
        .o_level_sum    (level_sum),
        .o_chk_err      (chk_err)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Monitor: every accepted write is matched against the oldest expected write.
    always @(negedge clk) begin
        if (!reset) begin
            if (mem_wr_valid && mem_wr_ready) begin
                hs_cyc.push_back(cyc + 1);
                check("sb_nonempty", 32'(sb.size() != 0), 1);
                if (sb.size() != 0) begin
                    wr_t e;
                    e = sb.pop_front();
                    check("wr_addr", 32'(mem_wr_addr), 32'(e.addr));
                    check("wr_data", 32'(mem_wr_data), 32'(e.data));
                end
            end
            if (done) done_cnt++;
        end
    end

    task automatic push_wr(input logic [ADDR_W-1:0] a, input logic [DATA_W-1:0] d);
        wr_t e;
        e.addr = a;
        e.data = d;
        sb.push_back(e);
    endtask

    task automatic do_reset();
        reset = 1'b1;
        start = 1'b0;
        capture_req = 1'b0;
        mem_wr_ready = 1'b0;
        stub_en = 1'b0;
        sb.delete();
        hs_cyc.delete();
        repeat (2) @(posedge clk);
        #1 reset = 1'b0;
    endtask

    task automatic pulse_start(output int s);
        @(posedge clk);
        #1 start = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
        s = cyc;
    endtask

    task automatic wait_valid(input int maxc);
        int n;
        n = 0;
        while (!mem_wr_valid && n < maxc) begin
            @(posedge clk);
            #1;
            n++;
        end
        check("valid_seen", 32'(mem_wr_valid), 1);
    endtask

    task automatic wait_done(input int maxc);
        int d0;
        int n;
        d0 = done_cnt;
        n = 0;
        while (done_cnt == d0 && n < maxc) begin
            @(negedge clk);
            n++;
        end
        repeat (3) @(negedge clk);
        check("done_once", 32'(done_cnt - d0), 1);
    endtask

    task automatic end_of_run(input int exp_sum);
        check("level_sum", 32'(level_sum), 32'(exp_sum));
        check("busy_idle", 32'(busy), 0);
        check("rnd_stop_idle", 32'(rnd_stop), 1);
        check("sb_drained", 32'(sb.size()), 0);
    endtask

    task automatic check_spacing(input int s, input int step);
        check("hs_count", 32'(hs_cyc.size()), NUM_WORDS);
        for (int i = 0; i < hs_cyc.size() && i < NUM_WORDS; i++) begin
            check("hs_timing", 32'(hs_cyc[i] - s), 32'(step * (i + 1)));
        end
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        // Reset values
        do_reset();
        check("rst_rnd_stop", 32'(rnd_stop), 1);
        check("rst_valid", 32'(mem_wr_valid), 0);
        check("rst_busy", 32'(busy), 0);
        check("rst_done", 32'(done), 0);
        check("rst_addr", 32'(mem_wr_addr), 0);
        check("rst_data", 32'(mem_wr_data), 0);
        check("rst_sum", 32'(level_sum), 0);
        check("rst_chk_err", 32'(chk_err), 0);

        // Basic run: spin 3, ready always high
        spin_len = 8'd3;
        mem_wr_ready = 1'b1;
        push_wr(4'd0, 7'h0F);
        push_wr(4'd1, 7'h7F);
        push_wr(4'd2, 7'h07);
        push_wr(4'd3, 7'h3F);
        pulse_start(s_cyc);
        check("busy_after_start", 32'(busy), 1);
        check("run_after_start", 32'(rnd_stop), 0);
        wait_done(200);
        end_of_run(20);
        check_spacing(s_cyc, 5);

        // Back-pressure: ready low for 5 WRITE cycles
        do_reset();
        spin_len = 8'd3;
        push_wr(4'd0, 7'h0F);
        push_wr(4'd1, 7'h7F);
        push_wr(4'd2, 7'h07);
        push_wr(4'd3, 7'h3F);
        pulse_start(s_cyc);
        wait_valid(20);
        repeat (5) begin
            check("stall_valid", 32'(mem_wr_valid), 1);
            check("stall_addr", 32'(mem_wr_addr), 0);
            check("stall_data", 32'(mem_wr_data), 32'h0F);
            check("stall_stop", 32'(rnd_stop), 1);
            @(posedge clk);
            #1;
        end
        mem_wr_ready = 1'b1;
        wait_done(200);
        end_of_run(20);

        // Early capture on the 2nd SPIN cycle, plus a start pulse mid-run
        do_reset();
        spin_len = 8'd200;
        mem_wr_ready = 1'b1;
        push_wr(4'd0, 7'h07);
        push_wr(4'd1, 7'h3F);
        push_wr(4'd2, 7'h03);
        push_wr(4'd3, 7'h1F);
        pulse_start(s_cyc);
        @(posedge clk);
        #1 capture_req = 1'b1;
        @(posedge clk);
        #1 capture_req = 1'b0;
        spin_len = 8'd3;
        check("settle_stop", 32'(rnd_stop), 1);
        check("settle_valid", 32'(mem_wr_valid), 0);
        @(posedge clk);
        #1;
        check("cap_write_valid", 32'(mem_wr_valid), 1);
        check("cap_write_stop", 32'(rnd_stop), 1);
        check("cap_data", 32'(mem_wr_data), 32'h07);
        @(posedge clk);
        #1 start = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
        check("restart_busy", 32'(busy), 1);
        wait_done(200);
        end_of_run(16);

        // Reset during WRITE of the second word
        do_reset();
        spin_len = 8'd3;
        pulse_start(s_cyc);
        wait_valid(20);
        push_wr(4'd0, 7'h0F);
        mem_wr_ready = 1'b1;
        @(posedge clk);
        #1 mem_wr_ready = 1'b0;
        wait_valid(20);
        check("w1_addr", 32'(mem_wr_addr), 1);
        check("w1_sum", 32'(level_sum), 4);
        reset = 1'b1;
        @(posedge clk);
        #1 reset = 1'b0;
        check("abort_valid", 32'(mem_wr_valid), 0);
        check("abort_stop", 32'(rnd_stop), 1);
        check("abort_addr", 32'(mem_wr_addr), 0);
        check("abort_busy", 32'(busy), 0);
        check("abort_sum", 32'(level_sum), 0);
        check("abort_data", 32'(mem_wr_data), 0);
        mem_wr_ready = 1'b1;
        repeat (10) @(posedge clk);
        #1;
        check("abort_idle_valid", 32'(mem_wr_valid), 0);
        check("abort_idle_busy", 32'(busy), 0);

        // Constant stub 7'b0000111 with spin_len=0 acting as 1
        do_reset();
        stub_en = 1'b1;
        stub_val = 7'b0000111;
        spin_len = 8'd0;
        mem_wr_ready = 1'b1;
        for (int i = 0; i < NUM_WORDS; i++) push_wr(4'(i), 7'b0000111);
        pulse_start(s_cyc);
        wait_done(200);
        end_of_run(12);
        check_spacing(s_cyc, 3);
`ifndef LFSR_CAPTURE_CHECK_EN
        check("chk_err_tied", 32'(chk_err), 0);
`endif

`ifdef LFSR_CAPTURE_CHECK_EN
        // Invalid code rejected, then a valid one written at addr 0
        do_reset();
        stub_en = 1'b1;
        stub_val = 7'b0000101;
        spin_len = 8'd3;
        mem_wr_ready = 1'b1;
        for (int i = 0; i < NUM_WORDS; i++) push_wr(4'(i), 7'b0000011);
        pulse_start(s_cyc);
        begin
            int n;
            n = 0;
            while (!chk_err && n < 20) begin
                @(posedge clk);
                #1;
                n++;
            end
        end
        check("chk_err_set", 32'(chk_err), 1);
        check("chk_no_write", 32'(mem_wr_valid), 0);
        check("chk_respin", 32'(rnd_stop), 0);
        stub_val = 7'b0000011;
        wait_done(200);
        end_of_run(8);
        check("chk_err_sticky", 32'(chk_err), 1);
`endif

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
